// File: rtl/alu_rs_pkg.sv
// Shared constants, types and the operand-resolution helper for the ALU reservation station.
package alu_rs_pkg;

  localparam int DATA_BUS_W = 32;
  localparam int TAG_BUS_W  = 4;
  localparam int ROOT_W     = 3;
  localparam int OP_W       = 5;

  localparam logic [TAG_BUS_W-1:0] TAG_FREE       = 4'b1111;
  localparam logic                 ALU_TAG_PREFIX = 1'b0;
  localparam logic [OP_W-1:0]      NOP            = 5'd0;

  typedef enum logic [1:0] {
    ST_FREE   = 2'b00,
    ST_WAIT   = 2'b01,
    ST_ISSUED = 2'b10
  } entry_state_e;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 5'd0,
    OP_LUI   = 5'd1,
    OP_AUIPC = 5'd2,
    OP_JAL   = 5'd3,
    OP_JALR  = 5'd4,
    OP_ADD   = 5'd5,
    OP_SUB   = 5'd6,
    OP_AND   = 5'd7,
    OP_OR    = 5'd8,
    OP_XOR   = 5'd9
  } alu_op_e;

  typedef struct packed {
    logic [TAG_BUS_W-1:0]  tag;
    logic [DATA_BUS_W-1:0] data;
  } operand_t;

  // Capture a broadcast for an unresolved operand; the ALU port wins if both match.
  function automatic operand_t resolve_operand(
    input operand_t              cur,
    input logic                  alu_en,
    input logic [TAG_BUS_W-1:0]  alu_tag,
    input logic [DATA_BUS_W-1:0] alu_data,
    input logic                  ls_en,
    input logic [TAG_BUS_W-1:0]  ls_tag,
    input logic [DATA_BUS_W-1:0] ls_data
  );
    operand_t r;
    r = cur;
    if (cur.tag != TAG_FREE) begin
      if (alu_en && (alu_tag == cur.tag)) begin
        r.tag  = TAG_FREE;
        r.data = alu_data;
      end else if (ls_en && (ls_tag == cur.tag)) begin
        r.tag  = TAG_FREE;
        r.data = ls_data;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_lowest_one8.sv
// 8-bit lowest-set-bit priority encoder: index of the lowest set bit plus an any-set flag.
module lowest_one8 (
  input  logic [7:0] vec_i,
  output logic [2:0] idx_o,
  output logic       any_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o = 3'd0;
    any_o = |vec_i;
    for (int i = 7; i >= 0; i--) begin
      if (vec_i[i]) idx_o = 3'(i);
    end
  end

endmodule

// File: rtl/alu_rs.sv
// Eight-entry ALU reservation station: allocates tags, snoops both CDBs, issues one ready entry per cycle.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_DEPTH = 8,
  parameter int DATA_W   = DATA_BUS_W,
  parameter int TAG_W    = TAG_BUS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              misTaken,
  input  logic              ALUen,
  input  logic [OP_W-1:0]   ALUop,
  input  logic [DATA_W-1:0] ALUoperandO,
  input  logic [DATA_W-1:0] ALUoperandT,
  input  logic [TAG_W-1:0]  ALUtagO,
  input  logic [TAG_W-1:0]  ALUtagT,
  input  logic [TAG_W-1:0]  ALUtagW,
  input  logic [DATA_W-1:0] ALUaddr,
  input  logic              ALUCDBen,
  input  logic [TAG_W-1:0]  ALUCDBtag,
  input  logic [DATA_W-1:0] ALUCDBdata,
  input  logic              LSCDBen,
  input  logic [TAG_W-1:0]  LSCDBtag,
  input  logic [DATA_W-1:0] LSCDBdata,
  output logic [ROOT_W-1:0] ALUfreeTag,
  output logic              ALUfull,
  output logic              ALUworkEn,
  output logic [OP_W-1:0]   ALUworkOp,
  output logic [DATA_W-1:0] ALUworkO,
  output logic [DATA_W-1:0] ALUworkT,
  output logic [TAG_W-1:0]  ALUworkTag,
  output logic [DATA_W-1:0] ALUworkAddr
);

  logic [7:0]        free_vec;
  logic [7:0]        ready_vec;
  logic              free_any;
  logic              ready_any;
  logic [ROOT_W-1:0] ready_idx;
  logic              issue_go;

  logic [OP_W-1:0]   op_arr   [RS_DEPTH];
  logic [DATA_W-1:0] o_arr    [RS_DEPTH];
  logic [DATA_W-1:0] t_arr    [RS_DEPTH];
  logic [DATA_W-1:0] addr_arr [RS_DEPTH];

  lowest_one8 u_free_sel (
    .vec_i (free_vec),
    .idx_o (ALUfreeTag),
    .any_o (free_any)
  );

  lowest_one8 u_ready_sel (
    .vec_i (ready_vec),
    .idx_o (ready_idx),
    .any_o (ready_any)
  );

  assign ALUfull  = ~free_any;
  assign issue_go = ready_any & ~misTaken;

  for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_entry
    entry_state_e      state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    operand_t          opo_q, opo_d, opt_q, opt_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic              dispatch_hit;
    logic              own_result;

    // A write to an occupied entry or with a non-ALU prefix is dropped.
    assign dispatch_hit = ALUen & ~misTaken & (ALUtagW[TAG_W-1] == ALU_TAG_PREFIX)
                        & (ALUtagW[ROOT_W-1:0] == ROOT_W'(gi)) & (state_q == ST_FREE);
    assign own_result   = ALUCDBen & (ALUCDBtag == {ALU_TAG_PREFIX, ROOT_W'(gi)});

    // Entry next state: flush, dispatch with CDB bypass, snoop/issue, or release on own result.
    always_comb begin
      state_d = state_q;
      op_d    = op_q;
      opo_d   = opo_q;
      opt_d   = opt_q;
      addr_d  = addr_q;
      if (misTaken) begin
        state_d   = ST_FREE;
        opo_d.tag = TAG_FREE;
        opt_d.tag = TAG_FREE;
      end else if (dispatch_hit) begin
        state_d = ST_WAIT;
        op_d    = ALUop;
        addr_d  = ALUaddr;
        opo_d   = resolve_operand('{tag: ALUtagO, data: ALUoperandO}, ALUCDBen, ALUCDBtag,
                                  ALUCDBdata, LSCDBen, LSCDBtag, LSCDBdata);
        opt_d   = resolve_operand('{tag: ALUtagT, data: ALUoperandT}, ALUCDBen, ALUCDBtag,
                                  ALUCDBdata, LSCDBen, LSCDBtag, LSCDBdata);
      end else if (state_q == ST_WAIT) begin
        opo_d = resolve_operand(opo_q, ALUCDBen, ALUCDBtag, ALUCDBdata, LSCDBen, LSCDBtag, LSCDBdata);
        opt_d = resolve_operand(opt_q, ALUCDBen, ALUCDBtag, ALUCDBdata, LSCDBen, LSCDBtag, LSCDBdata);
        if (issue_go && (ready_idx == ROOT_W'(gi))) state_d = ST_ISSUED;
      end else if (state_q == ST_ISSUED) begin
        if (own_result) state_d = ST_FREE;
      end
    end

    // Entry storage register.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= ST_FREE;
        op_q    <= NOP;
        opo_q   <= '{tag: TAG_FREE, data: '0};
        opt_q   <= '{tag: TAG_FREE, data: '0};
        addr_q  <= '0;
      end else begin
        state_q <= state_d;
        op_q    <= op_d;
        opo_q   <= opo_d;
        opt_q   <= opt_d;
        addr_q  <= addr_d;
      end
    end

    assign free_vec[gi]  = (state_q == ST_FREE);
    assign ready_vec[gi] = (state_q == ST_WAIT) & (opo_q.tag == TAG_FREE) & (opt_q.tag == TAG_FREE);
    assign op_arr[gi]    = op_q;
    assign o_arr[gi]     = opo_q.data;
    assign t_arr[gi]     = opt_q.data;
    assign addr_arr[gi]  = addr_q;
  end

  logic              work_en_q, work_en_d;
  logic [OP_W-1:0]   work_op_q, work_op_d;
  logic [DATA_W-1:0] work_o_q, work_o_d;
  logic [DATA_W-1:0] work_t_q, work_t_d;
  logic [TAG_W-1:0]  work_tag_q, work_tag_d;
  logic [DATA_W-1:0] work_addr_q, work_addr_d;

  // Issue mux: load the selected entry's fields, otherwise hold them and drop the valid.
  always_comb begin
    work_en_d   = 1'b0;
    work_op_d   = work_op_q;
    work_o_d    = work_o_q;
    work_t_d    = work_t_q;
    work_tag_d  = work_tag_q;
    work_addr_d = work_addr_q;
    if (issue_go) begin
      work_en_d   = 1'b1;
      work_op_d   = op_arr[ready_idx];
      work_o_d    = o_arr[ready_idx];
      work_t_d    = t_arr[ready_idx];
      work_tag_d  = {ALU_TAG_PREFIX, ready_idx};
      work_addr_d = addr_arr[ready_idx];
    end
  end

  // Issue output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work_en_q   <= 1'b0;
      work_op_q   <= NOP;
      work_o_q    <= '0;
      work_t_q    <= '0;
      work_tag_q  <= TAG_FREE;
      work_addr_q <= '0;
    end else begin
      work_en_q   <= work_en_d;
      work_op_q   <= work_op_d;
      work_o_q    <= work_o_d;
      work_t_q    <= work_t_d;
      work_tag_q  <= work_tag_d;
      work_addr_q <= work_addr_d;
    end
  end

  assign ALUworkEn   = work_en_q;
  assign ALUworkOp   = work_op_q;
  assign ALUworkO    = work_o_q;
  assign ALUworkT    = work_t_q;
  assign ALUworkTag  = work_tag_q;
  assign ALUworkAddr = work_addr_q;

endmodule

// File: tb/tb_alu_rs.sv
// Scenario bench for alu_rs: expected issues are queued at dispatch and popped when ALUworkEn is seen.
module tb_alu_rs;
  import alu_rs_pkg::*;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [31:0]     o;
    logic [31:0]     t;
    logic [3:0]      tag;
    logic [31:0]     addr;
  } issue_t;

  localparam logic [3:0] TF = 4'b1111;

  logic        clk = 1'b0;
  logic        rst;
  logic        misTaken, ALUen, ALUCDBen, LSCDBen;
  logic [OP_W-1:0] ALUop;
  logic [31:0] ALUoperandO, ALUoperandT, ALUaddr, ALUCDBdata, LSCDBdata;
  logic [3:0]  ALUtagO, ALUtagT, ALUtagW, ALUCDBtag, LSCDBtag;
  logic [2:0]  ALUfreeTag;
  logic        ALUfull, ALUworkEn;
  logic [OP_W-1:0] ALUworkOp;
  logic [31:0] ALUworkO, ALUworkT, ALUworkAddr;
  logic [3:0]  ALUworkTag;

  int vectors = 0;
  int miscompares = 0;
  issue_t sb[$];
  issue_t exp_r, obs;

  alu_rs dut (
    .clk(clk), .rst(rst), .misTaken(misTaken), .ALUen(ALUen), .ALUop(ALUop),
    .ALUoperandO(ALUoperandO), .ALUoperandT(ALUoperandT), .ALUtagO(ALUtagO), .ALUtagT(ALUtagT),
    .ALUtagW(ALUtagW), .ALUaddr(ALUaddr), .ALUCDBen(ALUCDBen), .ALUCDBtag(ALUCDBtag),
    .ALUCDBdata(ALUCDBdata), .LSCDBen(LSCDBen), .LSCDBtag(LSCDBtag), .LSCDBdata(LSCDBdata),
    .ALUfreeTag(ALUfreeTag), .ALUfull(ALUfull), .ALUworkEn(ALUworkEn), .ALUworkOp(ALUworkOp),
    .ALUworkO(ALUworkO), .ALUworkT(ALUworkT), .ALUworkTag(ALUworkTag), .ALUworkAddr(ALUworkAddr)
  );

  always #5 clk = ~clk;

  task automatic idle();
    misTaken = 1'b0; ALUen = 1'b0; ALUop = NOP;
    ALUoperandO = '0; ALUoperandT = '0; ALUtagO = TF; ALUtagT = TF; ALUtagW = 4'd0; ALUaddr = '0;
    ALUCDBen = 1'b0; ALUCDBtag = TF; ALUCDBdata = '0;
    LSCDBen = 1'b0; LSCDBtag = TF; LSCDBdata = '0;
  endtask

  task automatic drive_dispatch(input logic [OP_W-1:0] op, input logic [3:0] tagw,
                                input logic [31:0] o, input logic [31:0] t,
                                input logic [3:0] tago, input logic [3:0] tagt, input logic [31:0] addr);
    ALUen = 1'b1; ALUop = op; ALUtagW = tagw; ALUoperandO = o; ALUoperandT = t;
    ALUtagO = tago; ALUtagT = tagt; ALUaddr = addr;
  endtask

  task automatic alu_cdb(input logic [3:0] tag, input logic [31:0] data);
    ALUCDBen = 1'b1; ALUCDBtag = tag; ALUCDBdata = data;
  endtask

  task automatic ls_cdb(input logic [3:0] tag, input logic [31:0] data);
    LSCDBen = 1'b1; LSCDBtag = tag; LSCDBdata = data;
  endtask

  function automatic issue_t observed();
    return '{op: ALUworkOp, o: ALUworkO, t: ALUworkT, tag: ALUworkTag, addr: ALUworkAddr};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (ALUfull !== 1'b0) begin miscompares++; $display("FAIL rst_full got %b want 0", ALUfull); end
    vectors++; if (ALUfreeTag !== 3'd0) begin miscompares++; $display("FAIL rst_freetag got %0d want 0", ALUfreeTag); end
    vectors++; if (ALUworkEn !== 1'b0) begin miscompares++; $display("FAIL rst_worken got %b want 0", ALUworkEn); end
    vectors++; if (ALUworkTag !== TF) begin miscompares++; $display("FAIL rst_worktag got %h want f", ALUworkTag); end
    vectors++; if (ALUworkOp !== NOP || ALUworkO !== 32'd0) begin
      miscompares++; $display("FAIL rst_workop got op=%h o=%h want op=%h o=0", ALUworkOp, ALUworkO, NOP); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (ALUworkEn !== 1'b0 || ALUfreeTag !== 3'd0) begin
      miscompares++; $display("FAIL rst_release got en=%b free=%0d want en=0 free=0", ALUworkEn, ALUfreeTag); end
  endtask

  task automatic test_independent();
    sb.push_back('{op: OP_ADD, o: 32'd5, t: 32'd7, tag: 4'd0, addr: 32'h100});
    drive_dispatch(OP_ADD, 4'd0, 32'd5, 32'd7, TF, TF, 32'h100);
    @(negedge clk); idle();
    vectors++; if (ALUworkEn !== 1'b0) begin miscompares++; $display("FAIL indep_early got %b want 0", ALUworkEn); end
    vectors++; if (ALUfreeTag !== 3'd1) begin miscompares++; $display("FAIL indep_free_wait got %0d want 1", ALUfreeTag); end
    @(negedge clk);
    vectors++;
    if (ALUworkEn !== 1'b1 || sb.size() == 0) begin miscompares++; $display("FAIL indep_issue_en got %b want 1", ALUworkEn); end
    else begin
      exp_r = sb.pop_front(); obs = observed();
      vectors++; if (obs !== exp_r) begin miscompares++; $display("FAIL indep_issue got %h want %h", obs, exp_r); end
    end
    vectors++; if (ALUfreeTag !== 3'd1) begin miscompares++; $display("FAIL indep_free_issued got %0d want 1", ALUfreeTag); end
    @(negedge clk);
    vectors++; if (ALUworkEn !== 1'b0) begin miscompares++; $display("FAIL indep_one_shot got %b want 0", ALUworkEn); end
    alu_cdb(4'd0, 32'd12);
    @(negedge clk); idle();
    vectors++; if (ALUfreeTag !== 3'd0) begin miscompares++; $display("FAIL indep_release got %0d want 0", ALUfreeTag); end
  endtask

  task automatic test_snoop();
    sb.push_back('{op: OP_SUB, o: 32'hDEAD, t: 32'd3, tag: 4'd1, addr: 32'h104});
    drive_dispatch(OP_SUB, 4'd1, 32'd0, 32'd3, 4'b1010, TF, 32'h104);
    @(negedge clk); idle();
    @(negedge clk);
    vectors++; if (ALUworkEn !== 1'b0) begin miscompares++; $display("FAIL snoop_wait got %b want 0", ALUworkEn); end
    ls_cdb(4'b1010, 32'hDEAD);
    @(negedge clk); idle();
    vectors++; if (ALUworkEn !== 1'b0) begin miscompares++; $display("FAIL snoop_same_edge got %b want 0", ALUworkEn); end
    @(negedge clk);
    vectors++;
    if (ALUworkEn !== 1'b1 || sb.size() == 0) begin miscompares++; $display("FAIL snoop_issue_en got %b want 1", ALUworkEn); end
    else begin
      exp_r = sb.pop_front(); obs = observed();
      vectors++; if (obs !== exp_r) begin miscompares++; $display("FAIL snoop_issue got %h want %h", obs, exp_r); end
    end
    // Both ports resolve different operands of one entry at the same edge.
    sb.push_back('{op: OP_XOR, o: 32'hBB, t: 32'h66, tag: 4'd2, addr: 32'h108});
    drive_dispatch(OP_XOR, 4'd2, 32'd0, 32'd0, 4'b1011, 4'b0110, 32'h108);
    alu_cdb(4'd1, 32'd0);
    @(negedge clk); idle();
    alu_cdb(4'b0110, 32'h66); ls_cdb(4'b1011, 32'hBB);
    @(negedge clk); idle();
    @(negedge clk);
    vectors++;
    if (ALUworkEn !== 1'b1 || sb.size() == 0) begin miscompares++; $display("FAIL dual_snoop_en got %b want 1", ALUworkEn); end
    else begin
      exp_r = sb.pop_front(); obs = observed();
      vectors++; if (obs !== exp_r) begin miscompares++; $display("FAIL dual_snoop got %h want %h", obs, exp_r); end
    end
    alu_cdb(4'd2, 32'd0);
    @(negedge clk); idle();
  endtask

  task automatic test_bypass();
    sb.push_back('{op: OP_OR, o: 32'd1, t: 32'd9, tag: 4'd2, addr: 32'h10C});
    drive_dispatch(OP_OR, 4'd2, 32'd1, 32'd0, TF, 4'b0011, 32'h10C);
    alu_cdb(4'b0011, 32'd9);
    @(negedge clk); idle();
    @(negedge clk);
    vectors++;
    if (ALUworkEn !== 1'b1 || sb.size() == 0) begin miscompares++; $display("FAIL bypass_en got %b want 1", ALUworkEn); end
    else begin
      exp_r = sb.pop_front(); obs = observed();
      vectors++; if (obs !== exp_r) begin miscompares++; $display("FAIL bypass got %h want %h", obs, exp_r); end
    end
    alu_cdb(4'd2, 32'd0);
    @(negedge clk); idle();
  endtask

  task automatic test_collision();
    drive_dispatch(OP_AND, 4'd3, 32'd0, 32'h22, 4'b1001, TF, 32'h200);
    @(negedge clk);
    drive_dispatch(OP_OR, 4'd3, 32'h77, 32'h88, TF, TF, 32'h300);
    @(negedge clk); idle();
    @(negedge clk);
    vectors++; if (ALUworkEn !== 1'b0) begin miscompares++; $display("FAIL collision_ignored got %b want 0", ALUworkEn); end
    sb.push_back('{op: OP_AND, o: 32'h11, t: 32'h22, tag: 4'd3, addr: 32'h200});
    ls_cdb(4'b1001, 32'h11);
    @(negedge clk); idle();
    @(negedge clk);
    vectors++;
    if (ALUworkEn !== 1'b1 || sb.size() == 0) begin miscompares++; $display("FAIL collision_en got %b want 1", ALUworkEn); end
    else begin
      exp_r = sb.pop_front(); obs = observed();
      vectors++; if (obs !== exp_r) begin miscompares++; $display("FAIL collision_orig got %h want %h", obs, exp_r); end
    end
    alu_cdb(4'd3, 32'd0);
    @(negedge clk); idle();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      drive_dispatch(OP_ADD, 4'(i), 32'd0, 32'(i), 4'(8 + (i % 7)), TF, 32'h400 + 32'(4 * i));
      @(negedge clk); idle();
      vectors++;
      if (ALUfull !== (i == 7) || ALUworkEn !== 1'b0) begin
        miscompares++; $display("FAIL fill_%0d got full=%b en=%b want full=%b en=0", i, ALUfull, ALUworkEn, i == 7); end
      if (i < 7) begin
        vectors++; if (ALUfreeTag !== 3'(i + 1)) begin
          miscompares++; $display("FAIL fill_free_%0d got %0d want %0d", i, ALUfreeTag, i + 1); end
      end
    end
    sb.push_back('{op: OP_ADD, o: 32'h55, t: 32'd5, tag: 4'd5, addr: 32'h414});
    ls_cdb(4'b1101, 32'h55);
    @(negedge clk); idle();
    @(negedge clk);
    vectors++;
    if (ALUworkEn !== 1'b1 || sb.size() == 0) begin miscompares++; $display("FAIL fill_issue_en got %b want 1", ALUworkEn); end
    else begin
      exp_r = sb.pop_front(); obs = observed();
      vectors++; if (obs !== exp_r) begin miscompares++; $display("FAIL fill_issue got %h want %h", obs, exp_r); end
    end
    vectors++; if (ALUfull !== 1'b1) begin miscompares++; $display("FAIL fill_issued_full got %b want 1", ALUfull); end
    alu_cdb(4'd5, 32'd0);
    @(negedge clk); idle();
    vectors++; if (ALUfull !== 1'b0 || ALUfreeTag !== 3'd5) begin
      miscompares++; $display("FAIL fill_release got full=%b free=%0d want full=0 free=5", ALUfull, ALUfreeTag); end
  endtask

  task automatic test_flush();
    bit bad;
    misTaken = 1'b1;
    @(negedge clk); idle();
    vectors++; if (ALUfull !== 1'b0 || ALUfreeTag !== 3'd0) begin
      miscompares++; $display("FAIL flush_clear got full=%b free=%0d want full=0 free=0", ALUfull, ALUfreeTag); end
    for (int i = 0; i < 4; i++) begin
      drive_dispatch(OP_SUB, 4'(i), 32'd0, 32'd1, 4'(8 + i), TF, 32'h500 + 32'(4 * i));
      @(negedge clk);
    end
    sb.push_back('{op: OP_LUI, o: 32'h44, t: 32'h45, tag: 4'd4, addr: 32'h510});
    drive_dispatch(OP_LUI, 4'd4, 32'h44, 32'h45, TF, TF, 32'h510);
    @(negedge clk); idle();
    @(negedge clk);
    vectors++;
    if (ALUworkEn !== 1'b1 || sb.size() == 0) begin miscompares++; $display("FAIL flush_pre_en got %b want 1", ALUworkEn); end
    else begin
      exp_r = sb.pop_front(); obs = observed();
      vectors++; if (obs !== exp_r) begin miscompares++; $display("FAIL flush_pre got %h want %h", obs, exp_r); end
    end
    misTaken = 1'b1;
    drive_dispatch(OP_ADD, 4'd5, 32'd1, 32'd2, TF, TF, 32'h600);
    @(negedge clk); idle();
    vectors++; if (ALUworkEn !== 1'b0 || ALUfull !== 1'b0 || ALUfreeTag !== 3'd0) begin
      miscompares++; $display("FAIL flush_edge got en=%b full=%b free=%0d want 0 0 0", ALUworkEn, ALUfull, ALUfreeTag); end
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c < 4) ls_cdb(4'(8 + c), 32'(c));
      @(negedge clk); idle();
      if (ALUworkEn !== 1'b0) bad = 1'b1;
    end
    vectors++; if (bad) begin miscompares++; $display("FAIL flush_stale_issue got issue want none"); end
  endtask

  task automatic test_back_to_back();
    sb.push_back('{op: OP_JAL, o: 32'd1, t: 32'd2, tag: 4'd0, addr: 32'h700});
    drive_dispatch(OP_JAL, 4'd0, 32'd1, 32'd2, TF, TF, 32'h700);
    @(negedge clk);
    sb.push_back('{op: OP_JALR, o: 32'd3, t: 32'd4, tag: 4'd1, addr: 32'h704});
    drive_dispatch(OP_JALR, 4'd1, 32'd3, 32'd4, TF, TF, 32'h704);
    @(negedge clk);
    vectors++;
    if (ALUworkEn !== 1'b1 || sb.size() == 0) begin miscompares++; $display("FAIL b2b_0_en got %b want 1", ALUworkEn); end
    else begin
      exp_r = sb.pop_front(); obs = observed();
      vectors++; if (obs !== exp_r) begin miscompares++; $display("FAIL b2b_0 got %h want %h", obs, exp_r); end
    end
    // Dispatch into 2, issue 1 and release 0 share one edge.
    sb.push_back('{op: OP_AUIPC, o: 32'd5, t: 32'd6, tag: 4'd2, addr: 32'h708});
    drive_dispatch(OP_AUIPC, 4'd2, 32'd5, 32'd6, TF, TF, 32'h708);
    alu_cdb(4'd0, 32'd0);
    @(negedge clk); idle();
    vectors++;
    if (ALUworkEn !== 1'b1 || sb.size() == 0) begin miscompares++; $display("FAIL b2b_1_en got %b want 1", ALUworkEn); end
    else begin
      exp_r = sb.pop_front(); obs = observed();
      vectors++; if (obs !== exp_r) begin miscompares++; $display("FAIL b2b_1 got %h want %h", obs, exp_r); end
    end
    vectors++; if (ALUfreeTag !== 3'd0) begin miscompares++; $display("FAIL b2b_free got %0d want 0", ALUfreeTag); end
    @(negedge clk);
    vectors++;
    if (ALUworkEn !== 1'b1 || sb.size() == 0) begin miscompares++; $display("FAIL b2b_2_en got %b want 1", ALUworkEn); end
    else begin
      exp_r = sb.pop_front(); obs = observed();
      vectors++; if (obs !== exp_r) begin miscompares++; $display("FAIL b2b_2 got %h want %h", obs, exp_r); end
    end
    alu_cdb(4'd1, 32'd0);
    @(negedge clk);
    alu_cdb(4'd2, 32'd0);
    @(negedge clk); idle();
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL sb_drain got %0d left want 0", sb.size()); end
  endtask

  task automatic test_async_reset();
    drive_dispatch(OP_ADD, 4'd0, 32'd0, 32'd0, 4'b1000, TF, 32'h800);
    @(negedge clk); idle();
    vectors++; if (ALUfreeTag !== 3'd1) begin miscompares++; $display("FAIL areset_pre got %0d want 1", ALUfreeTag); end
    #2 rst = 1'b0;
    #1;
    vectors++; if (ALUfreeTag !== 3'd0 || ALUworkEn !== 1'b0 || ALUworkTag !== TF) begin
      miscompares++; $display("FAIL areset got free=%0d en=%b tag=%h want 0 0 f", ALUfreeTag, ALUworkEn, ALUworkTag); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    idle();
    test_reset();
    test_independent();
    test_snoop();
    test_bypass();
    test_collision();
    test_fill();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
